// File: rtl/addr_mult_ctrl.sv
// Issue/writeback controller for the 6-stage address multiply pipeline.
// Optional writeback forwarding is enabled by defining AMUL_WB_FWD_EN.
module addr_mult_ctrl #(
    parameter int MULT_LAT  = 6,
    parameter int ADD_LAT   = 2,
    parameter int NUM_AREGS = 8,
    parameter int AIDX_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_issue_vld,
    input  logic [AIDX_W-1:0]    i_aj_idx,
    input  logic [AIDX_W-1:0]    i_ak_idx,
    input  logic [AIDX_W-1:0]    i_ai_idx,
    output logic                 o_issue_rdy,
    output logic                 o_mult_start,
    input  logic                 i_add_issue,
    output logic                 o_add_stall,
`ifdef AMUL_WB_FWD_EN
    output logic                 o_fwd_j,
    output logic                 o_fwd_k,
`endif
    output logic                 o_wb_vld,
    output logic [AIDX_W-1:0]    o_wb_idx,
    output logic [NUM_AREGS-1:0] o_areg_busy,
    output logic [2:0]           o_inflight
);

    localparam int SLOT_STG = MULT_LAT - ADD_LAT - 1;

    logic                 vld_p [MULT_LAT];
    logic [AIDX_W-1:0]    idx_p [MULT_LAT];
    logic [NUM_AREGS-1:0] busy_nxt;
    logic [2:0]           inflight_nxt;
    logic                 unused_add;

    // The add unit always yields to a multiply; its issue strobe has no effect here.
    assign unused_add = i_add_issue;

    function automatic logic wb_hit(input logic wbv, input logic [AIDX_W-1:0] wbi,
                                    input logic [AIDX_W-1:0] idx);
        return wbv && (wbi == idx);
    endfunction

    function automatic logic reg_busy(input logic [NUM_AREGS-1:0] bsy, input logic wbv,
                                      input logic [AIDX_W-1:0] wbi,
                                      input logic [AIDX_W-1:0] idx);
`ifdef AMUL_WB_FWD_EN
        return bsy[idx] && !wb_hit(wbv, wbi, idx);
`else
        return bsy[idx] && !(wbv && 1'b0 && (wbi == idx));
`endif
    endfunction

    assign o_issue_rdy  = !reg_busy(o_areg_busy, o_wb_vld, o_wb_idx, i_aj_idx) &&
                          !reg_busy(o_areg_busy, o_wb_vld, o_wb_idx, i_ak_idx) &&
                          !reg_busy(o_areg_busy, o_wb_vld, o_wb_idx, i_ai_idx);
    assign o_mult_start = i_issue_vld && o_issue_rdy;
    assign o_add_stall  = vld_p[SLOT_STG];
    assign o_wb_vld     = vld_p[MULT_LAT-1];
    assign o_wb_idx     = idx_p[MULT_LAT-1];

`ifdef AMUL_WB_FWD_EN
    assign o_fwd_j = wb_hit(o_wb_vld, o_wb_idx, i_aj_idx);
    assign o_fwd_k = wb_hit(o_wb_vld, o_wb_idx, i_ak_idx);
`endif

    // Set after clear so a same-edge reissue keeps the reservation.
    always_comb begin
        busy_nxt = o_areg_busy;
        if (o_wb_vld)
            busy_nxt[o_wb_idx] = 1'b0;
        if (o_mult_start)
            busy_nxt[i_ai_idx] = 1'b1;
    end

    always_comb begin
        inflight_nxt = o_inflight;
        case ({o_mult_start, o_wb_vld})
            2'b10:   inflight_nxt = o_inflight + 3'd1;
            2'b01:   inflight_nxt = o_inflight - 3'd1;
            default: inflight_nxt = o_inflight;
        endcase
    end

    // Tracking pipe: stage 0 captures the start, final stage is the writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                vld_p[i] <= 1'b0;
                idx_p[i] <= '0;
            end
            o_areg_busy <= '0;
            o_inflight  <= '0;
        end else begin
            vld_p[0] <= o_mult_start;
            idx_p[0] <= i_ai_idx;
            for (int i = 1; i < MULT_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                idx_p[i] <= idx_p[i-1];
            end
            o_areg_busy <= busy_nxt;
            o_inflight  <= inflight_nxt;
        end
    end

endmodule
